mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Round-robin scheduler that shares one memory-controller burst port between `NUM_PORTS` requesters. Typical requesters are the per-channel video write paths and the image-processing read/write path. Each requester exposes the same read and write burst handshake the memory controller uses: valid out, ready in, burst_len, addr, data, burst_finish. The arbiter grants one burst at a time, latches its command, routes data and completion to the winner, and releases a stalled grant on timeout.

## Interface
- `NUM_PORTS`, 4, number of requesters (2..8).
- `MEM_DATA_LEN`, 64, data bus width.
- `ADDR_LEN`, 32, address width.
- `TIMEOUT_CYCLES`, 65535, maximum cycles a grant may stay BUSY without finish.

- `clk`  in  1  memory clock (mem_clk).
- `rst`  in  1  asynchronous, active-high reset.
- `req_rd_valid`  in  NUM_PORTS  per-port read request.
- `req_rd_ready`  out  NUM_PORTS  downstream `mem_rd_ready` routed to the read-granted port only.
- `req_rd_burst_len`  in  NUM_PORTS*10  per-port read burst length, port p at [10p+9:10p].
- `req_rd_addr`  in  NUM_PORTS*ADDR_LEN  per-port read start address.
- `req_rd_data`  out  MEM_DATA_LEN  `mem_rd_data` broadcast to all ports.
- `req_rd_burst_finish`  out  NUM_PORTS  completion pulse to the read-granted port.
- `req_wr_valid`, `req_wr_burst_len`, `req_wr_addr`  in  write-side equivalents of the read inputs.
- `req_wr_ready`, `req_wr_burst_finish`  out  write-side equivalents of the read outputs.
- `req_wr_data`  in  NUM_PORTS*MEM_DATA_LEN  per-port write data.
- `mem_rd_valid`, `mem_rd_burst_len[9:0]`, `mem_rd_addr`  out  downstream read command.
- `mem_rd_ready`, `mem_rd_data`, `mem_rd_burst_finish`  in  downstream read response.
- `mem_wr_valid`, `mem_wr_burst_len[9:0]`, `mem_wr_addr`, `mem_wr_data`  out  downstream write command and data.
- `mem_wr_ready`, `mem_wr_burst_finish`  in  downstream write response.
- `grant_id`  out  4  encoded slot {port, dir}; dir=0 read, dir=1 write.
- `busy`  out  1  high while a grant is active.
- `timeout_err`  out  1  one-cycle pulse when a grant is released by timeout.

## Operation
- Request vector: 2*NUM_PORTS slots. Slot 2p = port p read, slot 2p+1 = port p write.
- State machine: IDLE -> GRANT -> BUSY -> IDLE.
  - IDLE: if any slot is requesting, select the first requesting slot at or after `rr_ptr`, wrapping modulo 2*NUM_PORTS. Register `grant_id`, then go to GRANT. If no slot is requesting, stay in IDLE.
  - GRANT: latch the granted port's addr and burst_len into `mem_*_addr/burst_len`. Assert `mem_rd_valid` or `mem_wr_valid` according to dir. Set `busy`=1. Go to BUSY.
  - BUSY: hold valid, addr and len constant. On the matching `mem_*_burst_finish`:
    - drop valid and `busy`;
    - set `rr_ptr` = grant_id+1, wrapping;
    - return to IDLE.
- Finish on the non-granted direction is ignored.
- Requester dropping valid during BUSY does not abort the burst. The grant is held until finish or timeout.
- Routing (combinational from `grant_id` and state BUSY):
  - `req_*_ready[p]` = `mem_*_ready` for the granted slot, else 0.
  - `req_*_burst_finish[p]` = `mem_*_burst_finish` for the granted slot, else 0.
  - `mem_wr_data` = granted port's `req_wr_data`, else 0.
- Timeout: 16-bit counter, cleared on GRANT, incremented in BUSY. At `TIMEOUT_CYCLES`:
  - drop valid;
  - pulse `timeout_err`;
  - advance `rr_ptr` as on finish;
  - go to IDLE.
- Finish arriving on the same cycle as timeout counts as a normal finish; no error is flagged.
- Reset, including mid-burst: state=IDLE, `rr_ptr`=0, `grant_id`=0, and every output 0 (valid, ready, finish, addr, burst_len, data, busy, timeout_err). No pending grant survives reset.

## Timing
- Request to downstream valid: 2 cycles (IDLE sample, GRANT latch).
- Finish to next grant: finish cycle returns to IDLE, next cycle samples, the cycle after asserts valid. The bus is therefore idle 2 cycles between bursts.
- A request raised in the same cycle as another slot's finish competes in the following IDLE, using the updated `rr_ptr`.
- Ready, finish and write-data routing add zero latency.

## Structure
- Shared package holds: state encoding (IDLE=2'd0, GRANT=2'd1, BUSY=2'd2), the DIR_RD/DIR_WR constants, and the slot encoding helper.
- One sub-module: `rr_pick`, a combinational first-set-at-or-after-pointer search over a 2*NUM_PORTS vector. It returns index and found.
- Top module holds the FSM, latches, timeout counter and routing muxes.

## Test plan
- Port 1 read only, addr=240000, len=1 → `mem_rd_valid` 2 cycles later with addr=240000. `req_rd_ready[1]` follows `mem_rd_ready`. Finish reaches port 1 only. `grant_id`=2.
- Ports 0 and 2 both write continuously, `rr_ptr`=0 → grants alternate 1, 5, 1, 5. Each write carries the correct port's `req_wr_data`.
- Port 3 asserts read and write together → read (slot 6) is served first, then write (slot 7).
- Downstream never finishes, `TIMEOUT_CYCLES`=16 → valid drops after 16 BUSY cycles, `timeout_err` pulses once, next requester is granted.
- `rst` asserted mid-BUSY → all outputs 0 immediately. After release, the first request is granted from `rr_ptr`=0.
- Finish and timeout on the same cycle → `timeout_err` stays 0 and `rr_ptr` advances normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter.
// Contents: FSM state encoding, read/write direction constants, slot/length/
// counter widths, and the slot encoding helper {port, dir}.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } state_e;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    localparam int unsigned SLOT_W = 4;   // {port[2:0], dir}, up to 8 ports
    localparam int unsigned LEN_W  = 10;  // burst length width
    localparam int unsigned CNT_W  = 16;  // timeout counter width

    // Slot index of a port/direction pair: slot 2p is read, 2p+1 is write.
    function automatic logic [SLOT_W-1:0] slot_enc(input logic [SLOT_W-2:0] port,
                                                   input logic              dir);
        return {port, dir};
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the memory controller.
// req_* : per-port burst handshakes (packed, port p at slice p).
// mem_* : single downstream burst port.
// Modport slave  : the arbiter (serves requesters, drives the downstream command).
// Modport master : the surrounding system (requesters plus memory controller).
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS    = 4,
    parameter int unsigned MEM_DATA_LEN = 64,
    parameter int unsigned ADDR_LEN     = 32
) ();

    logic [NUM_PORTS-1:0]              req_rd_valid;
    logic [NUM_PORTS-1:0]              req_rd_ready;
    logic [NUM_PORTS*LEN_W-1:0]        req_rd_burst_len;
    logic [NUM_PORTS*ADDR_LEN-1:0]     req_rd_addr;
    logic [MEM_DATA_LEN-1:0]           req_rd_data;
    logic [NUM_PORTS-1:0]              req_rd_burst_finish;

    logic [NUM_PORTS-1:0]              req_wr_valid;
    logic [NUM_PORTS-1:0]              req_wr_ready;
    logic [NUM_PORTS*LEN_W-1:0]        req_wr_burst_len;
    logic [NUM_PORTS*ADDR_LEN-1:0]     req_wr_addr;
    logic [NUM_PORTS*MEM_DATA_LEN-1:0] req_wr_data;
    logic [NUM_PORTS-1:0]              req_wr_burst_finish;

    logic                              mem_rd_valid;
    logic                              mem_rd_ready;
    logic [LEN_W-1:0]                  mem_rd_burst_len;
    logic [ADDR_LEN-1:0]               mem_rd_addr;
    logic [MEM_DATA_LEN-1:0]           mem_rd_data;
    logic                              mem_rd_burst_finish;

    logic                              mem_wr_valid;
    logic                              mem_wr_ready;
    logic [LEN_W-1:0]                  mem_wr_burst_len;
    logic [ADDR_LEN-1:0]               mem_wr_addr;
    logic [MEM_DATA_LEN-1:0]           mem_wr_data;
    logic                              mem_wr_burst_finish;

    modport slave (
        input  req_rd_valid, req_rd_burst_len, req_rd_addr,
        input  req_wr_valid, req_wr_burst_len, req_wr_addr, req_wr_data,
        input  mem_rd_ready, mem_rd_data, mem_rd_burst_finish,
        input  mem_wr_ready, mem_wr_burst_finish,
        output req_rd_ready, req_rd_data, req_rd_burst_finish,
        output req_wr_ready, req_wr_burst_finish,
        output mem_rd_valid, mem_rd_burst_len, mem_rd_addr,
        output mem_wr_valid, mem_wr_burst_len, mem_wr_addr, mem_wr_data
    );

    modport master (
        output req_rd_valid, req_rd_burst_len, req_rd_addr,
        output req_wr_valid, req_wr_burst_len, req_wr_addr, req_wr_data,
        output mem_rd_ready, mem_rd_data, mem_rd_burst_finish,
        output mem_wr_ready, mem_wr_burst_finish,
        input  req_rd_ready, req_rd_data, req_rd_burst_finish,
        input  req_wr_ready, req_wr_burst_finish,
        input  mem_rd_valid, mem_rd_burst_len, mem_rd_addr,
        input  mem_wr_valid, mem_wr_burst_len, mem_wr_addr, mem_wr_data
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search.
// req_i   : request vector, one bit per slot.
// ptr_i   : slot where the search starts (wraps modulo N).
// idx_o   : first requesting slot at or after ptr_i.
// found_o : high when any slot is requesting.
module rr_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]      req_i,
    input  logic [SLOT_W-1:0] ptr_i,
    output logic [SLOT_W-1:0] idx_o,
    output logic              found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        // Scan from the farthest offset to the nearest so the last hit,
        // which is the one closest to ptr_i, wins.
        for (int unsigned k = N; k > 0; k--) begin
            if (req_i[(32'(ptr_i) + k - 1) % N]) begin
                idx_o   = SLOT_W'((32'(ptr_i) + k - 1) % N);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory-controller burst port between NUM_PORTS
// requesters (one read and one write slot each) in round-robin order.
// clk, rst    : memory clock, asynchronous active-high reset.
// bus         : requester and downstream burst handshakes (slave modport).
// grant_id    : current slot {port, dir}.
// busy        : a granted burst is in progress.
// timeout_err : one-cycle pulse when a grant is released by timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS      = 4,
    parameter int unsigned MEM_DATA_LEN   = 64,
    parameter int unsigned ADDR_LEN       = 32,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus,
    output logic [SLOT_W-1:0] grant_id,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned       NUM_SLOTS = 2 * NUM_PORTS;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   grant_q, grant_d, rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rd_valid_q, rd_valid_d, wr_valid_q, wr_valid_d;
    logic                busy_q, busy_d, tmo_q, tmo_d;
    logic [ADDR_LEN-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [LEN_W-1:0]    rd_len_q, rd_len_d, wr_len_q, wr_len_d;

    logic [NUM_SLOTS-1:0] req_vec;
    logic [SLOT_W-1:0]    pick_idx;
    logic                 pick_found;
    logic                 gnt_dir;
    logic                 fin;

    always_comb begin
        req_vec = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            req_vec[2*p]   = bus.req_rd_valid[p];
            req_vec[2*p+1] = bus.req_wr_valid[p];
        end
    end

    rr_pick #(.N(NUM_SLOTS)) u_pick (
        .req_i   (req_vec),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    assign gnt_dir = grant_q[0];
    // Only the granted direction's finish ends the burst.
    assign fin = (gnt_dir == DIR_RD) ? bus.mem_rd_burst_finish : bus.mem_wr_burst_finish;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            tmo_q      <= 1'b0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            rd_len_q   <= '0;
            wr_len_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            wr_valid_q <= wr_valid_d;
            busy_q     <= busy_d;
            tmo_q      <= tmo_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            rd_len_q   <= rd_len_d;
            wr_len_q   <= wr_len_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        rd_valid_d = rd_valid_q;
        wr_valid_d = wr_valid_q;
        busy_d     = busy_q;
        tmo_d      = 1'b0;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        rd_len_d   = rd_len_q;
        wr_len_d   = wr_len_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                    if (grant_q == slot_enc(p[SLOT_W-2:0], DIR_RD)) begin
                        rd_addr_d = bus.req_rd_addr[p*ADDR_LEN +: ADDR_LEN];
                        rd_len_d  = bus.req_rd_burst_len[p*LEN_W +: LEN_W];
                    end
                    if (grant_q == slot_enc(p[SLOT_W-2:0], DIR_WR)) begin
                        wr_addr_d = bus.req_wr_addr[p*ADDR_LEN +: ADDR_LEN];
                        wr_len_d  = bus.req_wr_burst_len[p*LEN_W +: LEN_W];
                    end
                end
                rd_valid_d = (gnt_dir == DIR_RD);
                wr_valid_d = (gnt_dir == DIR_WR);
                busy_d     = 1'b1;
                cnt_d      = '0;
                state_d    = BUSY;
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // Finish and timeout in the same cycle is a normal finish.
                if (fin || (cnt_q == TMO_LAST)) begin
                    rd_valid_d = 1'b0;
                    wr_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    tmo_d      = !fin;
                    rr_ptr_d   = (grant_q == LAST_SLOT) ? '0 : grant_q + 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Zero-latency routing of ready, finish and data for the granted slot.
    always_comb begin
        bus.req_rd_ready        = '0;
        bus.req_rd_burst_finish = '0;
        bus.req_wr_ready        = '0;
        bus.req_wr_burst_finish = '0;
        bus.req_rd_data         = '0;
        bus.mem_wr_data         = '0;
        if (state_q == BUSY) begin
            if (gnt_dir == DIR_RD) begin
                bus.req_rd_data = bus.mem_rd_data;
            end
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (grant_q == slot_enc(p[SLOT_W-2:0], DIR_RD)) begin
                    bus.req_rd_ready[p]        = bus.mem_rd_ready;
                    bus.req_rd_burst_finish[p] = bus.mem_rd_burst_finish;
                end
                if (grant_q == slot_enc(p[SLOT_W-2:0], DIR_WR)) begin
                    bus.req_wr_ready[p]        = bus.mem_wr_ready;
                    bus.req_wr_burst_finish[p] = bus.mem_wr_burst_finish;
                    bus.mem_wr_data            = bus.req_wr_data[p*MEM_DATA_LEN +: MEM_DATA_LEN];
                end
            end
        end
    end

    assign bus.mem_rd_valid     = rd_valid_q;
    assign bus.mem_rd_addr      = rd_addr_q;
    assign bus.mem_rd_burst_len = rd_len_q;
    assign bus.mem_wr_valid     = wr_valid_q;
    assign bus.mem_wr_addr      = wr_addr_q;
    assign bus.mem_wr_burst_len = wr_len_q;
    assign grant_id             = grant_q;
    assign busy                 = busy_q;
    assign timeout_err          = tmo_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a random
// round, checked against a slot-list round-robin reference model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int NP  = 4;
    localparam int NS  = 2 * NP;
    localparam int DW  = 64;
    localparam int AW  = 32;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] grant_id;
    logic       busy;
    logic       timeout_err;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_ptr  = 0;

    logic [NS-1:0] m_req;
    logic [AW-1:0] m_rd_addr [NP];
    logic [AW-1:0] m_wr_addr [NP];
    logic [9:0]    m_rd_len  [NP];
    logic [9:0]    m_wr_len  [NP];
    logic [DW-1:0] m_wr_data [NP];

    mem_port_arbiter_if #(.NUM_PORTS(NP), .MEM_DATA_LEN(DW), .ADDR_LEN(AW)) bus ();

    mem_port_arbiter #(
        .NUM_PORTS(NP), .MEM_DATA_LEN(DW), .ADDR_LEN(AW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: first requesting slot at or after ptr, wrapping.
    function automatic int model_pick(input logic [NS-1:0] v, input int ptr);
        for (int k = 0; k < NS; k++)
            if (v[(ptr + k) % NS]) return (ptr + k) % NS;
        return -1;
    endfunction

    function automatic logic outs_nonzero();
        return |{bus.mem_rd_valid, bus.mem_wr_valid, busy, timeout_err, grant_id,
                 bus.req_rd_ready, bus.req_wr_ready, bus.req_rd_burst_finish,
                 bus.req_wr_burst_finish, bus.mem_rd_addr, bus.mem_wr_addr,
                 bus.mem_rd_burst_len, bus.mem_wr_burst_len, bus.mem_wr_data, bus.req_rd_data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        for (int p = 0; p < NP; p++) begin
            bus.req_rd_valid[p]                 = m_req[2*p];
            bus.req_wr_valid[p]                 = m_req[2*p+1];
            bus.req_rd_addr[p*AW +: AW]         = m_rd_addr[p];
            bus.req_wr_addr[p*AW +: AW]         = m_wr_addr[p];
            bus.req_rd_burst_len[p*10 +: 10]    = m_rd_len[p];
            bus.req_wr_burst_len[p*10 +: 10]    = m_wr_len[p];
            bus.req_wr_data[p*DW +: DW]         = m_wr_data[p];
        end
    endtask

    task automatic randomize_port(input int p);
        m_rd_addr[p] = $urandom;
        m_wr_addr[p] = $urandom;
        m_rd_len[p]  = 10'($urandom_range(1, 1023));
        m_wr_len[p]  = 10'($urandom_range(1, 1023));
        m_wr_data[p] = {$urandom, $urandom};
    endtask

    task automatic zero_inputs();
        m_req = '0;
        for (int p = 0; p < NP; p++) begin
            m_rd_addr[p] = '0; m_wr_addr[p] = '0;
            m_rd_len[p]  = '0; m_wr_len[p]  = '0;
            m_wr_data[p] = '0;
        end
        drive_reqs();
        bus.mem_rd_ready = 1'b0; bus.mem_rd_data = '0; bus.mem_rd_burst_finish = 1'b0;
        bus.mem_wr_ready = 1'b0; bus.mem_wr_burst_finish = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!(bus.mem_rd_valid || bus.mem_wr_valid) && n < 64) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        zero_inputs();
        tick();
        tick();
        rst = 1'b0;
        exp_ptr = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        zero_inputs();
        bus.req_wr_valid[3] = 1'b1;
        tick();
        n_checks++;
        if (outs_nonzero() !== 1'b0)
            $display("FAIL reset_outputs: gid=%0d busy=%b rdv=%b wrv=%b required all zero",
                     grant_id, busy, bus.mem_rd_valid, bus.mem_wr_valid);
        else n_pass++;
        bus.req_wr_valid = '0;
        tick();
        rst = 1'b0;
        exp_ptr = 0;
        tick();
        n_checks++;
        if ({busy, bus.mem_rd_valid, bus.mem_wr_valid} !== 3'b000)
            $display("FAIL reset_idle: busy/rdv/wrv=%b required 000",
                     {busy, bus.mem_rd_valid, bus.mem_wr_valid});
        else n_pass++;
    endtask

    task automatic test_single_read();
        int exp;
        m_req = '0; m_req[2] = 1'b1;
        m_rd_addr[1] = 32'd240000; m_rd_len[1] = 10'd1;
        drive_reqs();
        exp = model_pick(m_req, exp_ptr);
        tick();
        n_checks++;
        if ({grant_id, bus.mem_rd_valid} !== {4'(exp), 1'b0})
            $display("FAIL sr_grant_cycle: gid=%0d rdv=%b required gid=%0d rdv=0", grant_id, bus.mem_rd_valid, exp);
        else n_pass++;
        tick();
        n_checks++;
        if ({bus.mem_rd_valid, bus.mem_wr_valid, busy, bus.mem_rd_addr, bus.mem_rd_burst_len} !==
            {3'b101, 32'd240000, 10'd1})
            $display("FAIL sr_command: rdv=%b wrv=%b busy=%b addr=%0d len=%0d required 1 0 1 240000 1",
                     bus.mem_rd_valid, bus.mem_wr_valid, busy, bus.mem_rd_addr, bus.mem_rd_burst_len);
        else n_pass++;
        bus.mem_rd_ready = 1'b1;
        #1;
        n_checks++;
        if ({bus.req_rd_ready, bus.req_wr_ready} !== 8'b0010_0000)
            $display("FAIL sr_ready_hi: rd=%b wr=%b required 0010 0000", bus.req_rd_ready, bus.req_wr_ready);
        else n_pass++;
        bus.mem_rd_ready = 1'b0;
        #1;
        n_checks++;
        if (bus.req_rd_ready !== 4'b0000)
            $display("FAIL sr_ready_lo: rd=%b required 0000", bus.req_rd_ready);
        else n_pass++;
        m_req = '0;
        drive_reqs();
        bus.mem_wr_burst_finish = 1'b1;
        tick();
        bus.mem_wr_burst_finish = 1'b0;
        n_checks++;
        if ({bus.mem_rd_valid, busy} !== 2'b11)
            $display("FAIL sr_hold: rdv/busy=%b required 11", {bus.mem_rd_valid, busy});
        else n_pass++;
        bus.mem_rd_burst_finish = 1'b1;
        #1;
        n_checks++;
        if ({bus.req_rd_burst_finish, bus.req_wr_burst_finish} !== 8'b0010_0000)
            $display("FAIL sr_finish_route: rd=%b wr=%b required 0010 0000",
                     bus.req_rd_burst_finish, bus.req_wr_burst_finish);
        else n_pass++;
        tick();
        bus.mem_rd_burst_finish = 1'b0;
        n_checks++;
        if ({bus.mem_rd_valid, busy} !== 2'b00)
            $display("FAIL sr_release: rdv/busy=%b required 00", {bus.mem_rd_valid, busy});
        else n_pass++;
        exp_ptr = (exp + 1) % NS;
    endtask

    task automatic test_round_robin_writes();
        int exp, p, n;
        do_reset();
        randomize_port(0);
        randomize_port(2);
        m_req = '0; m_req[1] = 1'b1; m_req[5] = 1'b1;
        drive_reqs();
        for (int b = 0; b < 4; b++) begin
            exp = model_pick(m_req, exp_ptr);
            p   = exp / 2;
            wait_valid(n);
            n_checks++;
            if (n !== 2) $display("FAIL rr_latency: cycles=%0d required 2", n);
            else n_pass++;
            n_checks++;
            if ({grant_id, bus.mem_wr_valid, bus.mem_rd_valid, bus.mem_wr_addr, bus.mem_wr_burst_len, bus.mem_wr_data} !==
                {4'(exp), 2'b10, m_wr_addr[p], m_wr_len[p], m_wr_data[p]})
                $display("FAIL rr_burst: gid=%0d addr=%h data=%h required gid=%0d addr=%h data=%h",
                         grant_id, bus.mem_wr_addr, bus.mem_wr_data, exp, m_wr_addr[p], m_wr_data[p]);
            else n_pass++;
            bus.mem_wr_ready = 1'b1;
            #1;
            n_checks++;
            if (bus.req_wr_ready !== 4'(1 << p))
                $display("FAIL rr_ready: wr=%b required %b", bus.req_wr_ready, 4'(1 << p));
            else n_pass++;
            bus.mem_wr_ready = 1'b0;
            bus.mem_wr_burst_finish = 1'b1;
            tick();
            bus.mem_wr_burst_finish = 1'b0;
            exp_ptr = (exp + 1) % NS;
            m_wr_data[p] = {$urandom, $urandom};
            drive_reqs();
        end
    endtask

    task automatic test_rd_wr_same_port();
        int exp, n;
        randomize_port(3);
        m_req = '0; m_req[6] = 1'b1; m_req[7] = 1'b1;
        drive_reqs();
        for (int b = 0; b < 2; b++) begin
            exp = model_pick(m_req, exp_ptr);
            wait_valid(n);
            n_checks++;
            if (grant_id !== 4'(exp)) $display("FAIL same_port_grant: gid=%0d required %0d", grant_id, exp);
            else n_pass++;
            n_checks++;
            if (exp % 2 == 0) begin
                if ({bus.mem_rd_valid, bus.mem_wr_valid, bus.mem_rd_addr} !== {2'b10, m_rd_addr[3]})
                    $display("FAIL same_port_rd: rdv=%b wrv=%b addr=%h required 1 0 %h",
                             bus.mem_rd_valid, bus.mem_wr_valid, bus.mem_rd_addr, m_rd_addr[3]);
                else n_pass++;
                bus.mem_rd_burst_finish = 1'b1;
            end else begin
                if ({bus.mem_rd_valid, bus.mem_wr_valid, bus.mem_wr_addr} !== {2'b01, m_wr_addr[3]})
                    $display("FAIL same_port_wr: rdv=%b wrv=%b addr=%h required 0 1 %h",
                             bus.mem_rd_valid, bus.mem_wr_valid, bus.mem_wr_addr, m_wr_addr[3]);
                else n_pass++;
                bus.mem_wr_burst_finish = 1'b1;
            end
            tick();
            bus.mem_rd_burst_finish = 1'b0;
            bus.mem_wr_burst_finish = 1'b0;
            exp_ptr = (exp + 1) % NS;
            m_req[exp] = 1'b0;
            drive_reqs();
        end
    endtask

    task automatic test_timeout();
        int exp, n;
        logic early;
        m_req = '0; m_req[0] = 1'b1; m_req[5] = 1'b1;
        drive_reqs();
        exp = model_pick(m_req, exp_ptr);
        wait_valid(n);
        n_checks++;
        if (grant_id !== 4'(exp)) $display("FAIL tmo_grant: gid=%0d required %0d", grant_id, exp);
        else n_pass++;
        n = 0;
        early = 1'b0;
        while (bus.mem_rd_valid && n < 100) begin
            if (timeout_err) early = 1'b1;
            tick();
            n++;
        end
        n_checks++;
        if ({n, early} !== {TMO, 1'b0})
            $display("FAIL tmo_length: busy_cycles=%0d early_err=%b required %0d 0", n, early, TMO);
        else n_pass++;
        n_checks++;
        if (timeout_err !== 1'b1) $display("FAIL tmo_pulse: err=%b required 1", timeout_err);
        else n_pass++;
        tick();
        n_checks++;
        if (timeout_err !== 1'b0) $display("FAIL tmo_pulse_end: err=%b required 0", timeout_err);
        else n_pass++;
        exp_ptr = (exp + 1) % NS;
        exp = model_pick(m_req, exp_ptr);
        wait_valid(n);
        n_checks++;
        if ({grant_id, bus.mem_wr_valid} !== {4'(exp), 1'b1})
            $display("FAIL tmo_next_grant: gid=%0d wrv=%b required %0d 1", grant_id, bus.mem_wr_valid, exp);
        else n_pass++;
        m_req = '0;
        drive_reqs();
        bus.mem_wr_burst_finish = 1'b1;
        tick();
        bus.mem_wr_burst_finish = 1'b0;
        exp_ptr = (exp + 1) % NS;
    endtask

    task automatic test_reset_mid_burst();
        int exp, n;
        randomize_port(1);
        randomize_port(2);
        m_req = '0; m_req[4] = 1'b1;
        bus.mem_rd_data = {$urandom, $urandom};
        drive_reqs();
        wait_valid(n);
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (outs_nonzero() !== 1'b0)
            $display("FAIL midreset_outputs: gid=%0d busy=%b rdv=%b required all zero",
                     grant_id, busy, bus.mem_rd_valid);
        else n_pass++;
        bus.mem_rd_data = '0;
        m_req = '0; m_req[2] = 1'b1; m_req[7] = 1'b1;
        drive_reqs();
        tick();
        tick();
        rst = 1'b0;
        exp_ptr = 0;
        exp = model_pick(m_req, exp_ptr);
        wait_valid(n);
        n_checks++;
        if ({n, grant_id, bus.mem_rd_addr} !== {2, 4'(exp), m_rd_addr[1]})
            $display("FAIL midreset_regrant: cycles=%0d gid=%0d addr=%h required 2 %0d %h",
                     n, grant_id, bus.mem_rd_addr, exp, m_rd_addr[1]);
        else n_pass++;
        m_req = '0;
        drive_reqs();
        bus.mem_rd_burst_finish = 1'b1;
        tick();
        bus.mem_rd_burst_finish = 1'b0;
        exp_ptr = (exp + 1) % NS;
    endtask

    task automatic test_finish_at_timeout();
        int exp, n;
        m_req = '0; m_req[3] = 1'b1;
        drive_reqs();
        exp = model_pick(m_req, exp_ptr);
        wait_valid(n);
        repeat (TMO - 1) tick();
        n_checks++;
        if ({grant_id, bus.mem_wr_valid} !== {4'(exp), 1'b1})
            $display("FAIL fat_hold: gid=%0d wrv=%b required %0d 1", grant_id, bus.mem_wr_valid, exp);
        else n_pass++;
        bus.mem_wr_burst_finish = 1'b1;
        tick();
        bus.mem_wr_burst_finish = 1'b0;
        n_checks++;
        if ({bus.mem_wr_valid, timeout_err} !== 2'b00)
            $display("FAIL fat_no_error: wrv=%b err=%b required 0 0", bus.mem_wr_valid, timeout_err);
        else n_pass++;
        exp_ptr = (exp + 1) % NS;
        m_req = '0; m_req[0] = 1'b1; m_req[3] = 1'b1;
        drive_reqs();
        exp = model_pick(m_req, exp_ptr);
        wait_valid(n);
        n_checks++;
        if (grant_id !== 4'(exp)) $display("FAIL fat_ptr_advance: gid=%0d required %0d", grant_id, exp);
        else n_pass++;
        m_req = '0;
        drive_reqs();
        bus.mem_rd_burst_finish = 1'b1;
        tick();
        bus.mem_rd_burst_finish = 1'b0;
        exp_ptr = (exp + 1) % NS;
    endtask

    task automatic test_random();
        int exp, p, n;
        logic rdy;
        logic [7:0] exp_rdy;
        for (int r = 0; r < 40; r++) begin
            for (int q = 0; q < NP; q++) randomize_port(q);
            m_req = NS'($urandom_range(1, (1 << NS) - 1));
            drive_reqs();
            exp = model_pick(m_req, exp_ptr);
            p   = exp / 2;
            wait_valid(n);
            n_checks++;
            if ({n, grant_id} !== {2, 4'(exp)})
                $display("FAIL rnd_grant: cycles=%0d gid=%0d required 2 %0d", n, grant_id, exp);
            else n_pass++;
            n_checks++;
            if (exp % 2 == 0) begin
                if ({bus.mem_rd_valid, bus.mem_wr_valid, bus.mem_rd_addr, bus.mem_rd_burst_len, bus.mem_wr_data} !==
                    {2'b10, m_rd_addr[p], m_rd_len[p], 64'd0})
                    $display("FAIL rnd_rd_cmd: addr=%h len=%0d wdata=%h required %h %0d 0",
                             bus.mem_rd_addr, bus.mem_rd_burst_len, bus.mem_wr_data, m_rd_addr[p], m_rd_len[p]);
                else n_pass++;
            end else begin
                if ({bus.mem_rd_valid, bus.mem_wr_valid, bus.mem_wr_addr, bus.mem_wr_burst_len, bus.mem_wr_data} !==
                    {2'b01, m_wr_addr[p], m_wr_len[p], m_wr_data[p]})
                    $display("FAIL rnd_wr_cmd: addr=%h len=%0d data=%h required %h %0d %h",
                             bus.mem_wr_addr, bus.mem_wr_burst_len, bus.mem_wr_data, m_wr_addr[p], m_wr_len[p], m_wr_data[p]);
                else n_pass++;
            end
            repeat ($urandom_range(0, 3)) tick();
            rdy = 1'($urandom_range(0, 1));
            bus.mem_rd_ready = rdy;
            bus.mem_wr_ready = rdy;
            #1;
            exp_rdy = (exp % 2 == 0) ? {4'(32'(rdy) << p), 4'b0} : {4'b0, 4'(32'(rdy) << p)};
            n_checks++;
            if ({bus.req_rd_ready, bus.req_wr_ready} !== exp_rdy)
                $display("FAIL rnd_ready: rd=%b wr=%b required %b", bus.req_rd_ready, bus.req_wr_ready, exp_rdy);
            else n_pass++;
            bus.mem_rd_ready = 1'b0;
            bus.mem_wr_ready = 1'b0;
            if (exp % 2 == 0) bus.mem_rd_burst_finish = 1'b1;
            else              bus.mem_wr_burst_finish = 1'b1;
            tick();
            bus.mem_rd_burst_finish = 1'b0;
            bus.mem_wr_burst_finish = 1'b0;
            exp_ptr = (exp + 1) % NS;
        end
    endtask

    initial begin
        rst = 1'b1;
        zero_inputs();
        test_reset();
        test_single_read();
        test_round_robin_writes();
        test_rd_wr_same_port();
        test_timeout();
        test_reset_mid_burst();
        test_finish_at_timeout();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
